fb_fetch_arbiter: RTL and testbench

//  Shares one framebuffer memory port between display scanline prefetch and a CPU requester.

---
 rtl/fb_pkg.sv | 15 +
 rtl/fb_fetch_sched.sv | 111 +++++++++++
 rtl/fb_fetch_arbiter.sv | 155 +++++++++++++++
 tb/tb_fb_fetch_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and timing constants for the framebuffer fetch path.
// The timing constants match the 640x480@60 timing generator.
package fb_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int V_LAST   = 524;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_DISP = 2'd1,
    ARB_CPU  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/fb_fetch_sched.sv
// Scanline prefetch scheduler: trigger decode, target bank, line base and sticky underrun.
// Build option FB_DBLBUF_EN adds an alternate frame base swapped at the frame-wrap trigger.
module fb_fetch_sched
  import fb_pkg::*;
#(
  parameter int ADDR_W         = 20,
  parameter int WORDS_PER_LINE = 160,
  parameter int H_ACTIVE       = fb_pkg::H_ACTIVE,
  parameter int V_ACTIVE       = fb_pkg::V_ACTIVE,
  parameter int V_LAST         = fb_pkg::V_LAST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        px,
  input  logic [9:0]        py,
  input  logic [ADDR_W-1:0] fb_base,
`ifdef FB_DBLBUF_EN
  input  logic [ADDR_W-1:0] fb_base_alt,
  input  logic              swap_req,
  output logic              swap_done,
`endif
  input  logic              fetch_done,
  output logic              trigger,
  output logic              fetch_pend,
  output logic              lb_bank,
  output logic [ADDR_W-1:0] line_base,
  output logic              underrun
);

  logic              frame_trig;
  logic              pend_q, pend_d;
  logic              bank_q, bank_d;
  logic              underrun_q, underrun_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] frame_base;

  assign frame_trig = (px == 10'(H_ACTIVE)) && (py == 10'(V_LAST));
  assign trigger    = (px == 10'(H_ACTIVE)) &&
                      ((py == 10'(V_LAST)) || (py < 10'(V_ACTIVE - 1)));

`ifdef FB_DBLBUF_EN
  logic sel_q, sel_d, swap_pend_q, swap_pend_d;

  // A swap request waits for the frame wrap; line 0 already uses the new base.
  always_comb begin
    swap_pend_d = swap_pend_q | swap_req;
    sel_d       = sel_q;
    swap_done   = 1'b0;
    if (frame_trig && swap_pend_d) begin
      swap_done   = 1'b1;
      sel_d       = ~sel_q;
      swap_pend_d = 1'b0;
    end
    frame_base = sel_d ? fb_base_alt : fb_base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= 1'b0;
      swap_pend_q <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      swap_pend_q <= swap_pend_d;
    end
  end
`else
  logic unused_frame_trig;
  assign unused_frame_trig = frame_trig;
  assign frame_base        = fb_base;
`endif

  // A final word accepted in the trigger cycle completes the old line, so no underrun.
  always_comb begin
    pend_d     = pend_q;
    bank_d     = bank_q;
    base_d     = base_q;
    underrun_d = underrun_q;
    if (fetch_done) pend_d = 1'b0;
    if (trigger) begin
      pend_d = 1'b1;
      if (pend_q && !fetch_done) underrun_d = 1'b1;
      if (py == 10'(V_LAST)) begin
        base_d = frame_base;
        bank_d = 1'b0;
      end else begin
        base_d = base_q + ADDR_W'(WORDS_PER_LINE);
        bank_d = ~py[0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= 1'b0;
      bank_q     <= 1'b0;
      base_q     <= '0;
      underrun_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      bank_q     <= bank_d;
      base_q     <= base_d;
      underrun_q <= underrun_d;
    end
  end

  assign fetch_pend = pend_q;
  assign lb_bank    = bank_q;
  assign line_base  = base_q;
  assign underrun   = underrun_q;

endmodule

// File: rtl/fb_fetch_arbiter.sv
// Shares one framebuffer memory port between scanline prefetch and a CPU requester.
// Build option FB_DBLBUF_EN adds fb_base_alt/swap_req/swap_done for double-buffered frames.
module fb_fetch_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W         = 20,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 160,
  parameter int H_ACTIVE       = fb_pkg::H_ACTIVE,
  parameter int V_ACTIVE       = fb_pkg::V_ACTIVE,
  parameter int V_LAST         = fb_pkg::V_LAST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        px,
  input  logic [9:0]        py,
  input  logic [ADDR_W-1:0] fb_base,
`ifdef FB_DBLBUF_EN
  input  logic [ADDR_W-1:0] fb_base_alt,
  input  logic              swap_req,
  output logic              swap_done,
`endif
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_we,
  output logic              lb_bank,
  output logic [7:0]        lb_waddr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              underrun,
  output arb_state_t        dbg_state
);

  // Handshake: a requester raises req with stable payload and holds it until the
  // 1-cycle ack; the ack cycle itself completes the transfer (and carries rdata).

  localparam logic [7:0] LAST_WORD = 8'(WORDS_PER_LINE - 1);

  arb_state_t        state_q, state_d;
  logic [7:0]        word_cnt_q, word_cnt_d;
  logic              stale_q, stale_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              trigger, fetch_pend, disp_ack, fetch_done;
  logic [ADDR_W-1:0] line_base;

  fb_fetch_sched #(
    .ADDR_W         (ADDR_W),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .H_ACTIVE       (H_ACTIVE),
    .V_ACTIVE       (V_ACTIVE),
    .V_LAST         (V_LAST)
  ) u_sched (
    .clk        (clk),
    .rst_n      (rst_n),
    .px         (px),
    .py         (py),
    .fb_base    (fb_base),
`ifdef FB_DBLBUF_EN
    .fb_base_alt(fb_base_alt),
    .swap_req   (swap_req),
    .swap_done  (swap_done),
`endif
    .fetch_done (fetch_done),
    .trigger    (trigger),
    .fetch_pend (fetch_pend),
    .lb_bank    (lb_bank),
    .line_base  (line_base),
    .underrun   (underrun)
  );

  // A stale display word belongs to a line abandoned by a later trigger.
  assign disp_ack   = (state_q == ARB_DISP) && mem_ack && !stale_q;
  assign fetch_done = disp_ack && (word_cnt_q == LAST_WORD);

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    stale_d     = stale_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (fetch_pend) begin
          state_d     = ARB_DISP;
          mem_we_d    = 1'b0;
          mem_addr_d  = line_base + ADDR_W'(word_cnt_q);
          mem_wdata_d = '0;
          stale_d     = trigger;
        end else if (cpu_req) begin
          state_d     = ARB_CPU;
          mem_we_d    = cpu_we;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          stale_d     = 1'b0;
        end
      end
      ARB_DISP: begin
        if (mem_ack) begin
          state_d = ARB_IDLE;
          stale_d = 1'b0;
        end else if (trigger) begin
          stale_d = 1'b1;
        end
      end
      ARB_CPU: begin
        if (mem_ack) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    if (trigger)       word_cnt_d = '0;
    else if (disp_ack) word_cnt_d = fetch_done ? 8'd0 : word_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      word_cnt_q  <= '0;
      stale_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      stale_q     <= stale_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_req   = (state_q != ARB_IDLE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign lb_we     = disp_ack;
  assign lb_waddr  = word_cnt_q;
  assign lb_wdata  = disp_ack ? mem_rdata : '0;
  assign cpu_ack   = (state_q == ARB_CPU) && mem_ack;
  assign cpu_rdata = cpu_ack ? mem_rdata : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fb_fetch_arbiter.sv
// Scoreboard bench for fb_fetch_arbiter: directed line fetches, CPU traffic, underrun and reset.
// With FB_DBLBUF_EN defined it also exercises the frame base swap.
module tb_fb_fetch_arbiter;
  import fb_pkg::*;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;
  localparam int WPL    = 160;
  localparam int LBW    = 1 + 8 + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  initial forever #5 clk = ~clk;

  logic [9:0]        px = '0, py = '0;
  logic [ADDR_W-1:0] fb_base = '0;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              mem_ack = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              cpu_ack, mem_req, mem_we, lb_we, lb_bank, underrun;
  logic [DATA_W-1:0] cpu_rdata, mem_wdata, lb_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        lb_waddr;
  arb_state_t        dbg_state;
`ifdef FB_DBLBUF_EN
  logic [ADDR_W-1:0] fb_base_alt = '0;
  logic              swap_req = 1'b0;
  logic              swap_done;
`endif

  fb_fetch_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .px         (px),
    .py         (py),
    .fb_base    (fb_base),
`ifdef FB_DBLBUF_EN
    .fb_base_alt(fb_base_alt),
    .swap_req   (swap_req),
    .swap_done  (swap_done),
`endif
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .lb_we      (lb_we),
    .lb_bank    (lb_bank),
    .lb_waddr   (lb_waddr),
    .lb_wdata   (lb_wdata),
    .underrun   (underrun),
    .dbg_state  (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] dat(input logic [ADDR_W-1:0] a);
    return 32'h5A00_0000 | {12'h000, a};
  endfunction

  // ---------------- memory responder ----------------
  int                ack_delay = 2;
  int                wait_cnt  = 0;
  logic [ADDR_W-1:0] last_wr_addr = '0;
  logic [DATA_W-1:0] last_wr_data = '0;

  initial forever begin
    @(posedge clk); #1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    if (!mem_req) begin
      wait_cnt = 0;
    end else if (wait_cnt >= ack_delay) begin
      mem_ack   = 1'b1;
      mem_rdata = mem_we ? '0 : dat(mem_addr);
      if (mem_we) begin
        last_wr_addr = mem_addr;
        last_wr_data = mem_wdata;
      end
      wait_cnt = 0;
    end else begin
      wait_cnt++;
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [LBW-1:0]    lb_exp_q[$];
  logic [LBW-1:0]    lb_cap_q[$];
  logic [DATA_W-1:0] cpu_exp_q[$];
  logic              lb_capture    = 1'b0;
  logic              cpu_order_chk = 1'b0;
  logic              cpu_ack_seen  = 1'b0;

  initial forever begin
    @(negedge clk);
    if (lb_we) begin
      if (lb_capture) lb_cap_q.push_back({lb_bank, lb_waddr, lb_wdata});
      else if (lb_exp_q.size() == 0) chk("lb_unexpected_write", 64'({lb_bank, lb_waddr, lb_wdata}), 64'h1_FFFF_FFFF_FFFF);
      else chk("lb_write", 64'({lb_bank, lb_waddr, lb_wdata}), 64'(lb_exp_q.pop_front()));
    end
    if (cpu_ack) begin
      cpu_ack_seen = 1'b1;
      if (cpu_exp_q.size() == 0) chk("cpu_unexpected_ack", 64'(cpu_rdata), 64'h1_0000_0000);
      else chk("cpu_rdata", 64'(cpu_rdata), 64'(cpu_exp_q.pop_front()));
      if (cpu_order_chk) chk("cpu_after_disp", 64'(lb_exp_q.size()), 64'd0);
    end
    if (mem_ack && mem_we) chk("we_only_cpu", 64'(cpu_ack), 64'd1);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
    if (px == 10'd799) begin
      px = 10'd0;
      py = (py == 10'd524) ? 10'd0 : py + 10'd1;
    end else begin
      px = px + 10'd1;
    end
  endtask

  task automatic set_pos(input int x, input int y);
    @(posedge clk); #1;
    px = 10'(x);
    py = 10'(y);
  endtask

  task automatic push_line(input logic bank, input logic [ADDR_W-1:0] base);
    for (int i = 0; i < WPL; i++)
      lb_exp_q.push_back({bank, 8'(i), dat(base + ADDR_W'(i))});
  endtask

  task automatic drain(input string name, input int max_cyc);
    int n = 0;
    while (lb_exp_q.size() != 0 && n < max_cyc) begin
      step();
      n++;
    end
    chk(name, 64'(lb_exp_q.size()), 64'd0);
  endtask

  task automatic cpu_xfer(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [DATA_W-1:0] exp_rd, input int max_cyc);
    int n = 0;
    cpu_exp_q.push_back(exp_rd);
    cpu_ack_seen = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    while (!cpu_ack_seen && n < max_cyc) begin
      step();
      n++;
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    chk("cpu_ack_seen", 64'(cpu_ack_seen), 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req",  64'(mem_req),   64'd0);
    chk("rst_mem_we",   64'(mem_we),    64'd0);
    chk("rst_mem_addr", 64'(mem_addr),  64'd0);
    chk("rst_lb_we",    64'(lb_we),     64'd0);
    chk("rst_lb_bank",  64'(lb_bank),   64'd0);
    chk("rst_lb_waddr", 64'(lb_waddr),  64'd0);
    chk("rst_cpu_ack",  64'(cpu_ack),   64'd0);
    chk("rst_underrun", 64'(underrun),  64'd0);
    chk("rst_state",    64'(dbg_state), 64'(ARB_IDLE));
    rst_n = 1'b1;

    // Line 0 trigger after reset fetches line 1 at base 0+160 into bank 1.
    push_line(1'b1, 20'd160);
    set_pos(630, 0);
    drain("t1_drain", 780);
    chk("t1_underrun", 64'(underrun), 64'd0);

    // Frame wrap fetches line 0 from fb_base into bank 0.
    fb_base = 20'h01000;
    push_line(1'b0, 20'h01000);
    set_pos(630, 524);
    drain("t2_drain", 780);

    cpu_xfer(1'b0, 20'h00123, 32'h0, dat(20'h00123), 50);

    // CPU write raised just after a trigger must wait for the whole line.
    push_line(1'b0, 20'h010A0);
    set_pos(635, 5);
    repeat (6) step();
    cpu_order_chk = 1'b1;
    cpu_xfer(1'b1, 20'h00FFF, 32'hDEAD_BEEF, 32'h0, 800);
    cpu_order_chk = 1'b0;
    chk("t3_lb_drained",  64'(lb_exp_q.size()), 64'd0);
    chk("t3_wr_addr",     64'(last_wr_addr), 64'h00FFF);
    chk("t3_wr_data",     64'(last_wr_data), 64'hDEAD_BEEF);
    repeat (20) step();
    chk("t3_underrun",    64'(underrun), 64'd0);

    // Slow memory: line 21 fetch overruns the next trigger.
    ack_delay  = 6;
    lb_capture = 1'b1;
    set_pos(635, 20);
    n = 0;
    while (!(py == 10'd21 && px == 10'd639) && n < 900) begin
      step();
      n++;
    end
    chk("t4_no_underrun_yet", 64'(underrun), 64'd0);
    step();
    step();
    chk("t4_underrun", 64'(underrun), 64'd1);
    lb_cap_q.delete();
    n = 0;
    while (lb_cap_q.size() == 0 && n < 100) begin
      step();
      n++;
    end
    chk("t4_restart_seen", 64'(lb_cap_q.size() != 0), 64'd1);
    if (lb_cap_q.size() != 0)
      chk("t4_restart_word", 64'(lb_cap_q[0]), 64'({1'b0, 8'd0, dat(20'h011E0)}));

    // Asynchronous reset in the middle of a display request.
    ack_delay = 2;
    set_pos(635, 30);
    n = 0;
    while (!mem_req && n < 50) begin
      step();
      n++;
    end
    chk("t5_req_seen", 64'(mem_req), 64'd1);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_mem_req",  64'(mem_req),  64'd0);
    chk("t5_lb_we",    64'(lb_we),    64'd0);
    chk("t5_cpu_ack",  64'(cpu_ack),  64'd0);
    chk("t5_underrun", 64'(underrun), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    lb_capture = 1'b0;
    lb_cap_q.delete();
    fb_base = 20'h02000;
    push_line(1'b0, 20'h02000);
    set_pos(630, 524);
    drain("t5_drain", 780);
    chk("t5_underrun_after", 64'(underrun), 64'd0);

`ifdef FB_DBLBUF_EN
    fb_base_alt = 20'h40000;
    set_pos(0, 100);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    chk("t6_no_early_swap", 64'(swap_done), 64'd0);
    push_line(1'b0, 20'h40000);
    set_pos(630, 524);
    repeat (10) step();
    chk("t6_swap_done", 64'(swap_done), 64'd1);
    step();
    chk("t6_swap_pulse", 64'(swap_done), 64'd0);
    drain("t6_drain", 780);
`endif

    repeat (10) step();
    chk("end_cpu_q", 64'(cpu_exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
